// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (hsync/vsync/de, raw x/y, line/frame pulses, frame count).
// Define VIDEO_TIMING_GEN_PATTERN_EN to drive an 8-bar colour pattern on rgb; otherwise rgb is tied low.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW       = $clog2(H_TOTAL),
    localparam int unsigned YW       = $clog2(V_TOTAL)
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic [23:0]   rgb
);

    localparam logic [XW-1:0] H_ACT_L  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_S = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_E = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_L  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_S = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYNC_E = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

    logic [XW-1:0] r_h_cnt;
    logic [YW-1:0] r_v_cnt;
    logic [XW-1:0] w_h_next;
    logic [YW-1:0] w_v_next;
    logic          w_h_wrap;

    logic          w_de;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_line_start;
    logic          w_frame_start;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;
    logic [7:0]    r_frame_cnt;

    // Vertical counter steps on the same edge the horizontal counter wraps (no half-line offset).
    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_h_next = w_h_wrap ? '0 : r_h_cnt + 1'b1;
        w_v_next = r_v_cnt;
        if (w_h_wrap) begin
            w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end
    end

    always_comb begin
        w_de          = (r_h_cnt < H_ACT_L) && (r_v_cnt < V_ACT_L);
        w_hs_act      = (r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E);
        w_vs_act      = (r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E);
        w_line_start  = (r_h_cnt == '0);
        w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (ce) begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    // Outputs describe the counter position held before the edge, giving one cycle of latency.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_de          <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else if (ce) begin
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_de          <= w_de;
            r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    localparam logic [XW-1:0] BAR_W = XW'(H_ACTIVE / 8);

    logic [2:0]  w_bar;
    logic [23:0] w_colour;
    logic [23:0] r_rgb;

    assign w_bar = 3'(r_h_cnt / BAR_W);

    // Blanking forces black so rgb stays aligned with and qualified by de.
    always_comb begin
        w_colour = '0;
        case (w_bar)
            3'd0:    w_colour = 24'hFFFFFF;
            3'd1:    w_colour = 24'hFFFF00;
            3'd2:    w_colour = 24'h00FFFF;
            3'd3:    w_colour = 24'h00FF00;
            3'd4:    w_colour = 24'hFF00FF;
            3'd5:    w_colour = 24'hFF0000;
            3'd6:    w_colour = 24'h0000FF;
            default: w_colour = 24'h000000;
        endcase
        if (!w_de) begin
            w_colour = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= '0;
        end else if (ce) begin
            r_rgb <= w_colour;
        end
    end

    assign rgb = r_rgb;
`else
    assign rgb = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a 16x8 raster (H=8/2/3/3, V=4/1/2/1, active-low syncs).
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    logic        sys_clk;
    logic        reset_n;
    logic        ce;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [3:0]  x;
    logic [2:0]  y;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;
    logic [23:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    video_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .HSYNC_POL(1'b0),
        .VSYNC_POL(1'b0)
    ) u_dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .x          (x),
        .y          (y),
        .line_start (line_start),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt),
        .rgb        (rgb)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [23:0] exp_rgb(input int unsigned px, input int unsigned py);
        logic [23:0] c;
        case (px)
            0:       c = 24'hFFFFFF;
            1:       c = 24'hFFFF00;
            2:       c = 24'h00FFFF;
            3:       c = 24'h00FF00;
            4:       c = 24'hFF00FF;
            5:       c = 24'hFF0000;
            6:       c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        if (!PAT_ON || px >= 8 || py >= 4) c = '0;
        return c;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"},  32'(x), 32'd0);
        check({tag, "_y"},  32'(y), 32'd0);
        check({tag, "_de"}, 32'(de), 32'd0);
        check({tag, "_hs"}, 32'(hsync), 32'd1);
        check({tag, "_vs"}, 32'(vsync), 32'd1);
        check({tag, "_ls"}, 32'(line_start), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_fc"}, 32'(frame_cnt), 32'd0);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
    endtask

    task automatic check_first_pos(input string tag, input int unsigned fc);
        check({tag, "_x"},  32'(x), 32'd0);
        check({tag, "_y"},  32'(y), 32'd0);
        check({tag, "_de"}, 32'(de), 32'd1);
        check({tag, "_hs"}, 32'(hsync), 32'd1);
        check({tag, "_vs"}, 32'(vsync), 32'd1);
        check({tag, "_ls"}, 32'(line_start), 32'd1);
        check({tag, "_fs"}, 32'(frame_start), 32'd1);
        check({tag, "_fc"}, 32'(frame_cnt), 32'(fc));
        check({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb(0, 0)));
    endtask

    initial begin
        int de_hi;
        int hs_lo;
        int vs_lo;
        int fs_seen;
        int cyc;
        int budget;
        bit found;
        int unsigned px;
        int unsigned py;

        reset_n = 1'b0;
        ce      = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("rst");

        reset_n = 1'b1;
        step();
        check_first_pos("rel", 1);

        // One full line: positions 0..15 of row 0.
        de_hi = int'(de);
        hs_lo = int'(!hsync);
        for (int p = 1; p < 16; p++) begin
            step();
            check("h_x",   32'(x), 32'(p));
            check("h_y",   32'(y), 32'd0);
            check("h_de",  32'(de), 32'(p < 8));
            check("h_hs",  32'(hsync), 32'(!(p >= 10 && p < 13)));
            check("h_ls",  32'(line_start), 32'd0);
            check("h_rgb", 32'(rgb), 32'(exp_rgb(p, 0)));
            de_hi += int'(de);
            hs_lo += int'(!hsync);
        end
        check("h_de_count", 32'(de_hi), 32'd8);
        check("h_hs_count", 32'(hs_lo), 32'd3);

        // Rest of frame 1, all of frame 2, and the first position of frame 3.
        vs_lo   = 0;
        fs_seen = 0;
        for (int c = 16; c <= 256; c++) begin
            step();
            px = c % 16;
            py = (c / 16) % 8;
            check("v_x",   32'(x), 32'(px));
            check("v_y",   32'(y), 32'(py));
            check("v_de",  32'(de), 32'(px < 8 && py < 4));
            check("v_hs",  32'(hsync), 32'(!(px >= 10 && px < 13)));
            check("v_vs",  32'(vsync), 32'(!(py >= 5 && py < 7)));
            check("v_ls",  32'(line_start), 32'(px == 0));
            check("v_fs",  32'(frame_start), 32'(px == 0 && py == 0));
            check("v_fc",  32'(frame_cnt), 32'(1 + c / 128));
            check("v_rgb", 32'(rgb), 32'(exp_rgb(px, py)));
            if (c < 128) vs_lo += int'(!vsync);
            fs_seen += int'(frame_start);
        end
        check("v_vs_count", 32'(vs_lo), 32'd32);
        check("v_fs_count", 32'(fs_seen), 32'd2);
        check("v_fc_final", 32'(frame_cnt), 32'd3);

        // Clock-enable stall of 5 cycles at x=3 in frame 3.
        cyc = 0;
        repeat (3) begin
            step();
            cyc++;
        end
        check("ce_pre_x", 32'(x), 32'd3);
        ce = 1'b0;
        repeat (5) begin
            step();
            cyc++;
            check("ce_hold_x",   32'(x), 32'd3);
            check("ce_hold_de",  32'(de), 32'd1);
            check("ce_hold_rgb", 32'(rgb), 32'(exp_rgb(3, 0)));
            check("ce_hold_fc",  32'(frame_cnt), 32'd3);
        end
        ce = 1'b1;
        step();
        cyc++;
        check("ce_resume_x", 32'(x), 32'd4);
        budget = 300;
        while (frame_start !== 1'b1 && budget > 0) begin
            step();
            cyc++;
            budget--;
        end
        check("ce_fs_reached", 32'(frame_start), 32'd1);
        check("ce_frame_period", 32'(cyc), 32'd133);
        check("ce_fc", 32'(frame_cnt), 32'd4);

        // Pulses held high while ce is low, without re-counting.
        ce = 1'b0;
        repeat (2) begin
            step();
            check("hold_fs", 32'(frame_start), 32'd1);
            check("hold_ls", 32'(line_start), 32'd1);
            check("hold_fc", 32'(frame_cnt), 32'd4);
        end
        ce = 1'b1;
        step();
        check("hold_rel_fs", 32'(frame_start), 32'd0);
        check("hold_rel_x",  32'(x), 32'd1);
        check("hold_rel_fc", 32'(frame_cnt), 32'd4);

        // Asynchronous reset mid-frame at (6,2).
        found  = 1'b0;
        budget = 300;
        while (!found && budget > 0) begin
            step();
            budget--;
            found = (x == 4'd6 && y == 3'd2);
        end
        check("seek_mid", 32'(found), 32'd1);
        check("mid_de_before", 32'(de), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("midrst_hold");
        reset_n = 1'b1;
        step();
        check_first_pos("restart", 1);
        step();
        check("restart2_x",  32'(x), 32'd1);
        check("restart2_fs", 32'(frame_start), 32'd0);
        check("restart2_fc", 32'(frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

- Generates 640x480@60-style raster timing (hsync, vsync, data-enable, pixel coordinates) for the HDMI output path.
- Sits directly downstream of the power-on reset generator: its inverted reset output drives this block's reset_n.
- Feeds the TMDS encoder/serializer stage and any pixel source that needs x/y coordinates.
- Optional built-in colour-bar pattern allows bring-up without a pixel source.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch, pixels (≥1)
- H_SYNC, 96, hsync pulse width, pixels (≥1)
- H_BP, 48, horizontal back porch, pixels (≥1)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines (≥1)
- V_SYNC, 2, vsync pulse width, lines (≥1)
- V_BP, 33, vertical back porch, lines (≥1)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync

Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
- sys_clk, in, 1, pixel-rate clock
- reset_n, in, 1, asynchronous active-low reset
- ce, in, 1, pixel clock enable; when low, all state and outputs hold
- hsync, out, 1, horizontal sync at HSYNC_POL when asserted
- vsync, out, 1, vertical sync at VSYNC_POL when asserted
- de, out, 1, high in the active region
- x, out, XW, horizontal counter value (raw, including blanking)
- y, out, YW, vertical counter value (raw, including blanking)
- line_start, out, 1, one-ce pulse at x==0
- frame_start, out, 1, one-ce pulse at x==0 && y==0
- frame_cnt, out, 8, frames started since reset, wraps 255→0
- rgb, out, 24, {R,G,B} pattern pixel; see Configuration

## Operation

Counters:
- h_cnt counts 0..H_TOTAL-1.
- v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1.
- Active region is first, then front porch, sync, back porch.

Decode, from the counter state before the edge:
- de = (h < H_ACTIVE) && (v < V_ACTIVE)
- hsync asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
- vsync asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC
- vsync changes on the same clock as hsync's line boundary (h wrap); there is no half-line offset.

Frame counter: frame_cnt increments on the same edge that registers frame_start=1.

Clock enable: with ce=0, counters, all registered outputs, and frame_cnt are frozen. Pulses stay high if they were high, and they do not re-trigger.

Reset (reset_n low, asynchronous):
- Counters go to (0,0).
- Outputs: x=0, y=0, de=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, line_start=0, frame_start=0, frame_cnt=0, rgb=0.
- Reset asserted mid-frame aborts the frame immediately. The next frame restarts at (0,0) with no partial blanking.

## Timing

- All outputs are registered with one-cycle latency relative to the counters. Outputs at edge N describe counter position N-1.
- The first enabled edge after reset_n rises registers position (0,0): de=1, line_start=1, frame_start=1, frame_cnt=1.
- Line period: H_TOTAL enabled cycles. Frame period: H_TOTAL·V_TOTAL enabled cycles.
- Wrap: at (H_TOTAL-1, V_TOTAL-1) the next position is (0,0) and frame_start fires.
- rgb is aligned with de on the same edge. rgb is 0 whenever de=0.

## Configuration

Macro: VIDEO_TIMING_GEN_PATTERN_EN.
- Defined: rgb shows 8 equal vertical bars, bar index = x / (H_ACTIVE/8). Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Undefined: rgb is tied to 24'h0 and no pattern logic is synthesised.
- Timing outputs are identical in both builds.

## Test plan

Small bench parameters: H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8), polarities 0, ce=1.

- Reset release: deassert reset_n → 1st edge: x=0, y=0, de=1, frame_start=1, frame_cnt=1, hsync=1, vsync=1.
- Horizontal timing: count one line → de high 8 cycles (x=0..7); hsync low exactly for x=10..12; line_start every 16 cycles.
- Vertical timing and wrap: run 2 frames → vsync low exactly for y=5..6 (32 cycles); frame_start every 128 cycles; frame_cnt=2 after the second.
- Clock enable: ce=0 for 5 cycles at x=3 → x, de, rgb frozen; after ce=1 the next edge shows x=4; frame period grows by 5 cycles.
- Mid-frame reset: pulse reset_n low at y=2, x=6, asynchronous to sys_clk → outputs hit reset values before the next edge; restart at (0,0) with frame_cnt=1.
- Pattern (macro defined, H_ACTIVE=8): row 0 rgb = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 for x=0..7; rgb=0 for x=8..15. With the macro undefined, rgb=0 always.
